// File: rtl/hazard_step_ctrl_if.sv
// Bundle of pipeline-side hazard inputs, run/step controls and the enable outputs
// exchanged between the datapath (master) and the hazard/step controller (slave).
interface hazard_step_ctrl_if #(
  parameter int NB_BITS = 32,
  parameter int NB_REG  = 5
);
  logic [NB_BITS-1:0] i_instr;
  logic               i_id_ex_mem_read;
  logic               i_id_ex_reg_write;
  logic [NB_REG-1:0]  i_id_ex_dst;
  logic               i_ex_mem_mem_read;
  logic [NB_REG-1:0]  i_ex_mem_dst;
  logic               i_start;
  logic               i_mode;
  logic               i_step;
  logic               o_pc_enb;
  logic               o_if_id_enb;
  logic               o_pipe_enb;
  logic               o_id_ex_bubble;
  logic               o_halted;
  logic [2:0]         o_state;
  logic [NB_BITS-1:0] o_cycle_cnt;

  modport master (
    output i_instr, i_id_ex_mem_read, i_id_ex_reg_write, i_id_ex_dst,
           i_ex_mem_mem_read, i_ex_mem_dst, i_start, i_mode, i_step,
    input  o_pc_enb, o_if_id_enb, o_pipe_enb, o_id_ex_bubble, o_halted,
           o_state, o_cycle_cnt
  );

  modport slave (
    input  i_instr, i_id_ex_mem_read, i_id_ex_reg_write, i_id_ex_dst,
           i_ex_mem_mem_read, i_ex_mem_dst, i_start, i_mode, i_step,
    output o_pc_enb, o_if_id_enb, o_pipe_enb, o_id_ex_bubble, o_halted,
           o_state, o_cycle_cnt
  );
endinterface

// File: rtl/hazard_step_ctrl.sv
// Pipeline hazard detection plus run / single-step / halt-drain sequencing.
// Enables and bubble are purely combinational from the current state and inputs.
module hazard_step_ctrl #(
  parameter int NB_BITS      = 32,
  parameter int NB_REG       = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  hazard_step_ctrl_if.slave bus
);

  localparam logic [5:0] OP_INSTR_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_INSTR_BEQ     = 6'b000100;
  localparam logic [5:0] OP_INSTR_BEN     = 6'b000101;
  localparam logic [5:0] OP_INSTR_HALT    = 6'b111111;
  localparam logic [5:0] FUNC_JR          = 6'b001000;
  localparam logic [5:0] FUNC_JALR        = 6'b001001;
  localparam logic [3:0] DRAIN_LOAD       = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         drain_cnt, drain_nxt;
  logic [NB_BITS-1:0] cycle_cnt;

  logic               adv;
  logic               pc_enb, if_id_enb, pipe_enb, id_ex_bubble;

  logic [5:0]         op, funct;
  logic [4:0]         rs_field, rt_field;
  logic [NB_REG-1:0]  rs, rt;
  logic               rs_nz, rt_nz;
  logic               is_halt, is_branch, is_jump_reg;
  logic               load_use, id_ex_match, ex_mem_match, branch_hz, hazard;
  logic               unused_instr_bits;

  assign op       = bus.i_instr[31:26];
  assign rs_field = bus.i_instr[25:21];
  assign rt_field = bus.i_instr[20:16];
  assign funct    = bus.i_instr[5:0];
  assign rs       = NB_REG'(rs_field);
  assign rt       = NB_REG'(rt_field);
  assign rs_nz    = (rs_field != 5'd0);
  assign rt_nz    = (rt_field != 5'd0);
  assign unused_instr_bits = ^bus.i_instr[15:6];

  assign is_halt     = (op == OP_INSTR_HALT);
  assign is_branch   = (op == OP_INSTR_BEQ) || (op == OP_INSTR_BEN);
  assign is_jump_reg = (op == OP_INSTR_SPECIAL) && ((funct == FUNC_JR) || (funct == FUNC_JALR));

  assign load_use = bus.i_id_ex_mem_read &&
                    ((rs_nz && (bus.i_id_ex_dst == rs)) || (rt_nz && (bus.i_id_ex_dst == rt)));

  // JR/JALR only read rs, so the rt match is qualified by the conditional-branch opcodes.
  assign id_ex_match  = (rs_nz && (bus.i_id_ex_dst == rs)) ||
                        (is_branch && rt_nz && (bus.i_id_ex_dst == rt));
  assign ex_mem_match = (rs_nz && (bus.i_ex_mem_dst == rs)) ||
                        (is_branch && rt_nz && (bus.i_ex_mem_dst == rt));
  assign branch_hz    = (is_branch || is_jump_reg) &&
                        ((bus.i_id_ex_reg_write && id_ex_match) ||
                         (bus.i_ex_mem_mem_read && ex_mem_match));
  assign hazard       = load_use || branch_hz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // HALT outranks hazards: it freezes fetch, bubbles ID/EX and starts the drain.
  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_cnt;
    adv          = 1'b0;
    pc_enb       = 1'b0;
    if_id_enb    = 1'b0;
    pipe_enb     = 1'b0;
    id_ex_bubble = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.i_start) state_nxt = bus.i_mode ? ST_STEP : ST_RUN;
      end
      ST_RUN: begin
        adv = 1'b1;
        if (is_halt) begin
          state_nxt = ST_DRAIN;
          drain_nxt = DRAIN_LOAD;
        end else if (bus.i_mode) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        adv = bus.i_step;
        if (bus.i_step && is_halt) begin
          state_nxt = ST_DRAIN;
          drain_nxt = DRAIN_LOAD;
        end else if (!bus.i_mode) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        pipe_enb     = 1'b1;
        id_ex_bubble = 1'b1;
        if (drain_cnt == 4'd0) state_nxt = ST_HALTED;
        else                   drain_nxt = drain_cnt - 4'd1;
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_IDLE;
        drain_nxt = 4'd0;
      end
    endcase

    if (adv) begin
      pipe_enb = 1'b1;
      if (is_halt || hazard) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_enb    = 1'b1;
        if_id_enb = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycle_cnt <= '0;
    end else if (pipe_enb && (cycle_cnt != {NB_BITS{1'b1}})) begin
      cycle_cnt <= cycle_cnt + NB_BITS'(1);
    end
  end

  assign bus.o_pc_enb       = pc_enb;
  assign bus.o_if_id_enb    = if_id_enb;
  assign bus.o_pipe_enb     = pipe_enb;
  assign bus.o_id_ex_bubble = id_ex_bubble;
  assign bus.o_halted       = (state == ST_HALTED);
  assign bus.o_state        = state;
  assign bus.o_cycle_cnt    = cycle_cnt;

endmodule

// File: tb/tb_hazard_step_ctrl.sv
// Directed-vector bench for hazard_step_ctrl; expected responses are queued by the
// stimulus process and checked by an independent negedge monitor.
module tb_hazard_step_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                         S_DRAIN = 3'd3, S_HALTED = 3'd4;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] FN_ADD = 6'h20, FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [31:0] NOP  = 32'h0;
  localparam logic [31:0] HALT = {6'b111111, 5'd5, 21'd0};

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_cnt = 32'd0;

  logic       hz_mr = 1'b0, hz_rw = 1'b0, hz_exr = 1'b0;
  logic [4:0] hz_idd = 5'd0, hz_exd = 5'd0;

  hazard_step_ctrl_if #(.NB_BITS(32), .NB_REG(5)) bus ();

  hazard_step_ctrl #(.NB_BITS(32), .NB_REG(5), .DRAIN_CYCLES(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] fn);
    return {6'b000000, rs, rt, 5'd1, 5'd0, fn};
  endfunction

  task automatic setHazard(input logic mr, input logic rw, input logic [4:0] idd,
                           input logic exr, input logic [4:0] exd);
    hz_mr = mr; hz_rw = rw; hz_idd = idd; hz_exr = exr; hz_exd = exd;
  endtask

  // Drives one cycle of inputs just after the rising edge and queues the response
  // expected at the following falling edge.
  task automatic applyStimulus(input string name, input logic rst, input logic [31:0] instr,
                               input logic start, input logic mode, input logic step,
                               input logic pc, input logic ifid, input logic pipe,
                               input logic bub, input logic [2:0] st);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_rst                 = rst;
    bus.i_instr           = instr;
    bus.i_start           = start;
    bus.i_mode            = mode;
    bus.i_step            = step;
    bus.i_id_ex_mem_read  = hz_mr;
    bus.i_id_ex_reg_write = hz_rw;
    bus.i_id_ex_dst       = hz_idd;
    bus.i_ex_mem_mem_read = hz_exr;
    bus.i_ex_mem_dst      = hz_exd;
    if (rst) exp_cnt = 32'd0;
    e.name = name;
    e.ctl  = {pc, ifid, pipe, bub, (st == S_HALTED), st};
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    if (pipe && !rst) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] got;
    got = {bus.o_pc_enb, bus.o_if_id_enb, bus.o_pipe_enb, bus.o_id_ex_bubble,
           bus.o_halted, bus.o_state};
    checks++;
    if (got !== e.ctl) begin
      failures++;
      $display("[TB] FAIL %s ctl {pc,ifid,pipe,bub,halted,state} got=%b want=%b", e.name, got, e.ctl);
    end
    checks++;
    if (bus.o_cycle_cnt !== e.cnt) begin
      failures++;
      $display("[TB] FAIL %s cycle_cnt got=%0d want=%0d", e.name, bus.o_cycle_cnt, e.cnt);
    end
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    bus.i_instr = NOP; bus.i_start = 1'b0; bus.i_mode = 1'b0; bus.i_step = 1'b0;
    bus.i_id_ex_mem_read = 1'b0; bus.i_id_ex_reg_write = 1'b0; bus.i_id_ex_dst = 5'd0;
    bus.i_ex_mem_mem_read = 1'b0; bus.i_ex_mem_dst = 5'd0;

    setHazard(0, 0, 5'd0, 0, 5'd0);
    applyStimulus("reset",         1, NOP, 0, 0, 0, 0, 0, 0, 0, S_IDLE);
    applyStimulus("reset_start",   1, NOP, 1, 0, 0, 0, 0, 0, 0, S_IDLE);
    applyStimulus("idle_start",    0, NOP, 1, 0, 0, 0, 0, 0, 0, S_IDLE);
    for (int i = 0; i < 10; i++)
      applyStimulus("run_nop",     0, NOP, (i == 3), 0, 0, 1, 1, 1, 0, S_RUN);

    setHazard(1, 1, 5'd5, 0, 5'd0);
    applyStimulus("load_use_rs",   0, rtype(5'd5, 5'd6, FN_ADD), 0, 0, 0, 0, 0, 1, 1, S_RUN);
    setHazard(0, 0, 5'd0, 0, 5'd0);
    applyStimulus("after_load",    0, rtype(5'd5, 5'd6, FN_ADD), 0, 0, 0, 1, 1, 1, 0, S_RUN);
    setHazard(1, 1, 5'd6, 0, 5'd0);
    applyStimulus("load_use_rt",   0, rtype(5'd5, 5'd6, FN_ADD), 0, 0, 0, 0, 0, 1, 1, S_RUN);
    setHazard(0, 1, 5'd5, 0, 5'd0);
    applyStimulus("alu_dep",       0, rtype(5'd5, 5'd6, FN_ADD), 0, 0, 0, 1, 1, 1, 0, S_RUN);
    setHazard(1, 1, 5'd0, 0, 5'd0);
    applyStimulus("load_r0",       0, rtype(5'd0, 5'd0, FN_ADD), 0, 0, 0, 1, 1, 1, 0, S_RUN);
    setHazard(0, 0, 5'd0, 1, 5'd3);
    applyStimulus("beq_exmem",     0, itype(OP_BEQ, 5'd3, 5'd4), 0, 0, 0, 0, 0, 1, 1, S_RUN);
    setHazard(0, 0, 5'd0, 1, 5'd0);
    applyStimulus("beq_r0",        0, itype(OP_BEQ, 5'd0, 5'd0), 0, 0, 0, 1, 1, 1, 0, S_RUN);
    setHazard(0, 1, 5'd4, 0, 5'd0);
    applyStimulus("bne_idex_rt",   0, itype(OP_BNE, 5'd2, 5'd4), 0, 0, 0, 0, 0, 1, 1, S_RUN);
    setHazard(0, 1, 5'd7, 0, 5'd0);
    applyStimulus("jr_idex_rs",    0, rtype(5'd7, 5'd0, FN_JR), 0, 0, 0, 0, 0, 1, 1, S_RUN);
    setHazard(0, 1, 5'd9, 0, 5'd0);
    applyStimulus("jr_rt_ignored", 0, rtype(5'd7, 5'd9, FN_JR), 0, 0, 0, 1, 1, 1, 0, S_RUN);
    setHazard(0, 0, 5'd0, 1, 5'd8);
    applyStimulus("jalr_exmem",    0, rtype(5'd8, 5'd0, FN_JALR), 0, 0, 0, 0, 0, 1, 1, S_RUN);
    setHazard(0, 0, 5'd0, 0, 5'd0);
    applyStimulus("run_to_step",   0, NOP, 0, 1, 0, 1, 1, 1, 0, S_RUN);

    // Three step pulses over twenty cycles; the middle one lands on a load-use stall.
    for (int i = 0; i < 20; i++) begin
      logic stp;
      stp = (i == 2) || (i == 9) || (i == 15);
      if (i >= 8 && i <= 10) setHazard(1, 1, 5'd5, 0, 5'd0);
      else                   setHazard(0, 0, 5'd0, 0, 5'd0);
      if (stp && i == 9)
        applyStimulus("step_stall", 0, rtype(5'd5, 5'd6, FN_ADD), 0, 1, 1, 0, 0, 1, 1, S_STEP);
      else if (stp)
        applyStimulus("step_adv",   0, rtype(5'd5, 5'd6, FN_ADD), 0, 1, 1, 1, 1, 1, 0, S_STEP);
      else
        applyStimulus("step_wait",  0, rtype(5'd5, 5'd6, FN_ADD), (i == 4), 1, 0, 0, 0, 0, 0, S_STEP);
    end

    setHazard(0, 0, 5'd0, 0, 5'd0);
    applyStimulus("step_to_run",   0, NOP, 0, 0, 0, 0, 0, 0, 0, S_STEP);
    applyStimulus("run_again",     0, NOP, 0, 0, 0, 1, 1, 1, 0, S_RUN);
    setHazard(1, 1, 5'd5, 0, 5'd0);
    applyStimulus("halt_priority", 0, HALT, 0, 0, 0, 0, 0, 1, 1, S_RUN);
    setHazard(0, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus("drain",       0, NOP, (i == 0), i[0], 1, 0, 0, 1, 1, S_DRAIN);
    for (int i = 0; i < 3; i++)
      applyStimulus("halted",      0, NOP, 1, 0, 1, 0, 0, 0, 0, S_HALTED);

    applyStimulus("reset_halted",  1, NOP, 0, 0, 0, 0, 0, 0, 0, S_IDLE);
    applyStimulus("idle_to_step",  0, NOP, 1, 1, 0, 0, 0, 0, 0, S_IDLE);
    applyStimulus("step_halt_idle",0, HALT, 0, 1, 0, 0, 0, 0, 0, S_STEP);
    applyStimulus("step_halt",     0, HALT, 0, 1, 1, 0, 0, 1, 1, S_STEP);
    applyStimulus("drain_first",   0, NOP, 0, 1, 0, 0, 0, 1, 1, S_DRAIN);
    applyStimulus("reset_in_drain",1, NOP, 0, 1, 1, 0, 0, 0, 0, S_IDLE);
    applyStimulus("reset_hold",    1, NOP, 1, 0, 0, 0, 0, 0, 0, S_IDLE);
    applyStimulus("idle_no_start", 0, NOP, 0, 0, 1, 0, 0, 0, 0, S_IDLE);
    applyStimulus("idle_stays",    0, NOP, 0, 0, 0, 0, 0, 0, 0, S_IDLE);

    repeat (3) @(negedge i_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_queue pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_step_ctrl.md
HAZARD_STEP_CTRL -- requirements
Module: hazard_step_ctrl

Interface
REQ-001 Parameter NB_BITS, default 32, datapath/instruction width.
REQ-002 Parameter NB_REG, default 5, register-number width.
REQ-003 Parameter DRAIN_CYCLES, default 4, cycles downstream stages keep clocking after HALT detection; legal range 1..15.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_instr  in  NB_BITS  instruction currently held in IF/ID.
REQ-007 i_id_ex_mem_read  in  1  instruction in ID/EX is a load.
REQ-008 i_id_ex_reg_write  in  1  instruction in ID/EX writes a register.
REQ-009 i_id_ex_dst  in  NB_REG  destination register of instruction in ID/EX.
REQ-010 i_ex_mem_mem_read  in  1  instruction in EX/MEM is a load.
REQ-011 i_ex_mem_dst  in  NB_REG  destination register of instruction in EX/MEM.
REQ-012 i_start  in  1  one-cycle pulse, leave IDLE.
REQ-013 i_mode  in  1  0 = continuous run, 1 = single-step.
REQ-014 i_step  in  1  one-cycle pulse, advance pipeline one cycle in step mode.
REQ-015 o_pc_enb  out  1  PC register load enable.
REQ-016 o_if_id_enb  out  1  IF/ID latch load enable.
REQ-017 o_pipe_enb  out  1  clock enable for ID/EX, EX/MEM, MEM/WB latches and register-file write.
REQ-018 o_id_ex_bubble  out  1  force ID/EX control fields to zero (NOP) this cycle.
REQ-019 o_halted  out  1  pipeline drained after HALT.
REQ-020 o_state  out  3  FSM state: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
REQ-021 o_cycle_cnt  out  NB_BITS  count of cycles in which o_pipe_enb was 1.

Function
REQ-022 adv (internal) SHALL be 1 in RUN, in STEP when i_step=1, else 0; o_pipe_enb = adv, or 1 in DRAIN.
REQ-023 rs = i_instr[25:21], rt = i_instr[20:16], op = i_instr[31:26]; fields compared only when source register nonzero.
REQ-024 Load-use hazard: i_id_ex_mem_read=1 and i_id_ex_dst equals nonzero rs or rt.
REQ-025 Branch hazard: op is OP_INSTR_BEQ/OP_INSTR_BEN, or op is OP_INSTR_SPECIAL with funct FUNC_JR/FUNC_JALR, and (i_id_ex_reg_write=1 with i_id_ex_dst matching rs or rt) or (i_ex_mem_mem_read=1 with i_ex_mem_dst matching rs or rt); JR/JALR compare rs only.
REQ-026 stall = adv and (load-use or branch hazard) and op not OP_INSTR_HALT.
REQ-027 When adv=1 and stall=1: o_pc_enb=0, o_if_id_enb=0, o_id_ex_bubble=1.
REQ-028 When adv=1, stall=0, op not HALT: o_pc_enb=1, o_if_id_enb=1, o_id_ex_bubble=0.
REQ-029 When adv=1 and op=OP_INSTR_HALT: o_pc_enb=0, o_if_id_enb=0, o_id_ex_bubble=1; next state DRAIN, drain counter loaded DRAIN_CYCLES-1.
REQ-030 HALT detection has priority over hazards; HALT never enters ID/EX.
REQ-031 All enable/bubble outputs are combinational from state and inputs; no added latency.
REQ-032 IDLE: o_pc_enb=o_if_id_enb=o_pipe_enb=0, bubble 0; i_start=1 -> RUN if i_mode=0, STEP if i_mode=1.
REQ-033 RUN: i_mode=1 -> STEP next cycle; current cycle still advances.
REQ-034 STEP: i_mode=0 -> RUN next cycle; a step pulse coinciding with a stall is consumed by the bubble cycle.
REQ-035 DRAIN: o_pc_enb=o_if_id_enb=0, o_id_ex_bubble=1, o_pipe_enb=1 regardless of i_mode/i_step; counter decrements each cycle; at 0 -> HALTED, so DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-036 HALTED: all enables 0, o_halted=1; exit only via reset.
REQ-037 i_start ignored outside IDLE; i_step ignored outside STEP.
REQ-038 o_cycle_cnt increments by 1 per cycle with o_pipe_enb=1; saturates at all-ones, no wrap.

Reset
REQ-039 i_rst=1 SHALL immediately force state IDLE, drain counter 0, o_cycle_cnt 0, o_halted 0, all enables and bubble 0, including mid-DRAIN or mid-stall.
REQ-040 First state transition after reset release SHALL occur on the first rising edge with i_rst=0.

Verification
REQ-041 Reset, i_start with i_mode=0, ten NOPs -> o_state=1, o_pc_enb=o_if_id_enb=o_pipe_enb=1 each cycle, o_cycle_cnt=10.
REQ-042 RUN, i_id_ex_mem_read=1, i_id_ex_dst=5, IF/ID instr rs=5 -> one cycle pc/if_id enb=0, bubble=1; next cycle (load moved on) normal advance.
REQ-043 RUN, BEQ rs=3 with i_ex_mem_mem_read=1, i_ex_mem_dst=3 -> stall; same with dst=0 and rs=0 -> no stall.
REQ-044 Step mode, i_step pulsed 3 times over 20 cycles -> o_pipe_enb high exactly 3 cycles, o_cycle_cnt=3.
REQ-045 HALT in IF/ID, DRAIN_CYCLES=4 -> o_state=3 for 4 cycles with o_pipe_enb=1, then o_state=4, o_halted=1, o_cycle_cnt stops.
REQ-046 i_rst asserted during DRAIN second cycle -> outputs zero asynchronously, o_state=0 before next edge.
